// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking weight-fetch datapath:
// controller state encoding, default widths and membrane saturation limits.
package snn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam int ADDR_W_DEF = 4;
    localparam int DW_DEF     = 8;
    localparam int MEM_W      = 12;
    localparam int V_MAX      = 2047;
    localparam int V_MIN      = -2048;
    localparam int CNT_MAX    = 15;

    // Output 1 wins only on a strictly larger spike count; ties go to output 0.
    function automatic logic [7:0] make_prediction(input logic [3:0] c0, input logic [3:0] c1);
        logic win;
        win = (c1 > c0);
        return {(win ? c1 : c0), 3'b000, win};
    endfunction

endpackage

// File: rtl/lif_update.sv
// Leaky integrate-and-fire step for one neuron: leak, add the accumulated
// weight sum, saturate to the membrane range and compare against threshold.
module lif_update
    import snn_pkg::*;
#(
    parameter int THRESH     = 64,
    parameter int LEAK_SHIFT = 2
) (
    input  logic signed [MEM_W-1:0] v_i,
    input  logic signed [MEM_W-1:0] sum_i,
    output logic signed [MEM_W-1:0] v_next_o,
    output logic                    fire_o
);

    // Two guard bits: |v - leak| <= 2048 and |sum| <= 2048 never overflow 14 bits.
    localparam int EW = MEM_W + 2;
    localparam logic signed [EW-1:0]    SAT_HI = EW'(V_MAX);
    localparam logic signed [EW-1:0]    SAT_LO = EW'(V_MIN);
    localparam logic signed [MEM_W-1:0] TH     = MEM_W'(THRESH);

    logic signed [EW-1:0] v_ext;
    logic signed [EW-1:0] sum_ext;
    logic signed [EW-1:0] acc;

    always_comb begin
        v_ext   = {{2{v_i[MEM_W-1]}}, v_i};
        sum_ext = {{2{sum_i[MEM_W-1]}}, sum_i};
        acc     = v_ext - (v_ext >>> LEAK_SHIFT) + sum_ext;
        if (acc > SAT_HI) begin
            v_next_o = MEM_W'(V_MAX);
        end else if (acc < SAT_LO) begin
            v_next_o = MEM_W'(V_MIN);
        end else begin
            v_next_o = acc[MEM_W-1:0];
        end
        fire_o = (v_next_o >= TH);
    end

endmodule

// File: rtl/weight_fetch_lif.sv
// Two-output LIF classifier: fetches one weight per active input spike over a
// request/valid port, integrates per output, and reports the winning output.
//
//   state    | meaning
//   S_IDLE   | waiting for start
//   S_REQ    | issue a read for the next active input, or move on to update
//   S_WAIT   | read outstanding, address held until w_valid
//   S_UPDATE | leak/integrate/fire for the current output
//   S_DONE   | prediction valid, done pulse
module weight_fetch_lif
    import snn_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DW         = DW_DEF,
    parameter int NUM_STEPS  = 4,
    parameter int THRESH     = 64,
    parameter int LEAK_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        spikes_in,
    output logic              w_req,
    output logic [ADDR_W-1:0] w_addr,
    input  logic              w_valid,
    input  logic [DW-1:0]     w_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        prediction
);

    state_t                   state_q, state_d;
    logic [7:0]               spikes_q, spikes_d;
    logic [7:0]               pending_q, pending_d;
    logic                     out_q, out_d;
    logic [3:0]               step_q, step_d;
    logic [3:0]               step_nxt;
    logic signed [MEM_W-1:0]  sum_q, sum_d;
    logic signed [MEM_W-1:0]  v0_q, v0_d, v1_q, v1_d;
    logic [3:0]               cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic                     w_req_q, w_req_d;
    logic [ADDR_W-1:0]        w_addr_q, w_addr_d;
    logic [7:0]               pred_q, pred_d;

    logic [2:0]               idx;
    logic signed [MEM_W-1:0]  v_cur, v_new, v_upd;
    logic                     fire;
    state_t                   after_update;

    assign v_cur = out_q ? v1_q : v0_q;

    lif_update #(
        .THRESH     (THRESH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lif (
        .v_i      (v_cur),
        .sum_i    (sum_q),
        .v_next_o (v_new),
        .fire_o   (fire)
    );

    function automatic logic [3:0] cnt_inc(input logic [3:0] c);
        return (c == 4'(CNT_MAX)) ? c : c + 4'd1;
    endfunction

    always_comb begin
        state_d   = state_q;
        spikes_d  = spikes_q;
        pending_d = pending_q;
        out_d     = out_q;
        step_d    = step_q;
        sum_d     = sum_q;
        v0_d      = v0_q;
        v1_d      = v1_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        w_req_d   = 1'b0;
        w_addr_d  = w_addr_q;
        pred_d    = pred_q;
        step_nxt  = step_q + 4'd1;
        v_upd     = fire ? '0 : v_new;
        // With no active inputs there is nothing to fetch, so update back-to-back.
        after_update = (spikes_q == 8'h00) ? S_UPDATE : S_REQ;

        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i]) idx = 3'(i);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    spikes_d  = spikes_in;
                    pending_d = spikes_in;
                    out_d     = 1'b0;
                    step_d    = 4'd0;
                    sum_d     = '0;
                    v0_d      = '0;
                    v1_d      = '0;
                    cnt0_d    = 4'd0;
                    cnt1_d    = 4'd0;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (pending_q != 8'h00) begin
                    w_req_d        = 1'b1;
                    w_addr_d       = ADDR_W'({out_q, idx});
                    pending_d[idx] = 1'b0;
                    state_d        = S_WAIT;
                end else begin
                    state_d = S_UPDATE;
                end
            end
            S_WAIT: begin
                if (w_valid) begin
                    sum_d   = sum_q + {{(MEM_W-DW){w_data[DW-1]}}, w_data};
                    state_d = S_REQ;
                end
            end
            S_UPDATE: begin
                if (!out_q) begin
                    v0_d = v_upd;
                    if (fire) cnt0_d = cnt_inc(cnt0_q);
                end else begin
                    v1_d = v_upd;
                    if (fire) cnt1_d = cnt_inc(cnt1_q);
                end
                sum_d     = '0;
                pending_d = spikes_q;
                if (!out_q) begin
                    out_d   = 1'b1;
                    state_d = after_update;
                end else if (step_nxt == 4'(NUM_STEPS)) begin
                    pred_d  = make_prediction(cnt0_d, cnt1_d);
                    state_d = S_DONE;
                end else begin
                    step_d  = step_nxt;
                    out_d   = 1'b0;
                    state_d = after_update;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            spikes_q  <= 8'h00;
            pending_q <= 8'h00;
            out_q     <= 1'b0;
            step_q    <= 4'd0;
            sum_q     <= '0;
            v0_q      <= '0;
            v1_q      <= '0;
            cnt0_q    <= 4'd0;
            cnt1_q    <= 4'd0;
            w_req_q   <= 1'b0;
            w_addr_q  <= '0;
            pred_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            spikes_q  <= spikes_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            step_q    <= step_d;
            sum_q     <= sum_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            w_req_q   <= w_req_d;
            w_addr_q  <= w_addr_d;
            pred_q    <= pred_d;
        end
    end

    assign w_req      = w_req_q;
    assign w_addr     = w_addr_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign prediction = pred_q;

endmodule

// File: doc/weight_fetch_lif.md
WEIGHT_FETCH_LIF -- requirements
Module: weight_fetch_lif

Interface
REQ-001 Parameter ADDR_W, default 4, weight-memory address width; address = {out_idx[0], in_idx[2:0]}.
REQ-002 Parameter DW, default 8, weight width, two's-complement signed.
REQ-003 Parameter NUM_STEPS, default 4, timesteps per inference (1..15).
REQ-004 Parameter THRESH, default 64, signed firing threshold.
REQ-005 Parameter LEAK_SHIFT, default 2, membrane leak shift.
REQ-006 clk  in  1  the only clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 start  in  1  one-cycle inference request.
REQ-009 spikes_in  in  8  input spike vector, sampled on accepted start.
REQ-010 w_req  out  1  one-cycle weight read request pulse.
REQ-011 w_addr  out  ADDR_W  read address, valid while w_req high and held until w_valid.
REQ-012 w_valid  in  1  one-cycle pulse, w_data valid.
REQ-013 w_data  in  DW  returned weight.
REQ-014 busy  out  1  inference in progress.
REQ-015 done  out  1  one-cycle pulse at inference end.
REQ-016 prediction  out  8  {winner spike count[3:0], 3'b000, winner index}.

Function
REQ-017 FSM states IDLE, REQ, WAIT, UPDATE, DONE; start accepted only in IDLE, ignored otherwise.
REQ-018 IDLE + start: latch spikes_in, clear both membranes and spike counters, step=0, out=0, busy=1, go to REQ.
REQ-019 REQ: select lowest in_idx not yet visited with latched spike bit 1; drive w_req=1 for exactly one cycle with w_addr={out,in_idx}; go to WAIT; if no such bit remains, go to UPDATE without a request.
REQ-020 WAIT: hold w_addr; on w_valid add sign-extended w_data into 12-bit signed sum, return to REQ; w_valid outside WAIT ignored; no timeout.
REQ-021 Inputs with spike bit 0 SHALL never be requested; each step issues popcount(spikes) requests per output, out 0 before out 1.
REQ-022 UPDATE (1 cycle): v_next = v - (v >>> LEAK_SHIFT) + sum, computed at 14 bits, saturated to 12-bit signed [-2048, 2047].
REQ-023 If v_next >= THRESH: v=0, counter of that output +1, saturating at 15; else v=v_next; sum cleared.
REQ-024 After UPDATE of out 0 go to REQ for out 1; after out 1, step+1; step==NUM_STEPS goes to DONE, else out=0, REQ.
REQ-025 DONE: winner = output with larger count, tie -> 0; register prediction; done=1 one cycle; busy=0; go to IDLE.
REQ-026 prediction SHALL hold until next DONE; it is not cleared by start.
REQ-027 start arriving in the DONE cycle is ignored.

Reset
REQ-028 rst_n low at any clock edge, including mid-transaction: state IDLE, w_req=0, w_addr=0, busy=0, done=0, prediction=0x00, membranes, sums, counters, step cleared; a w_valid pending from before reset is ignored.

Structure
REQ-029 Shared package snn_pkg holds state enum, ADDR_W/DW defaults, membrane width (12) and saturation limits.
REQ-030 One sub-module lif_update: combinational leak/add/saturate/threshold for one neuron, instantiated once, time-shared between outputs.

Verification
REQ-031 Responder model returning w_data 1 cycle after each w_req; weights addr 0-7 = +40, addr 8-15 = +70; spikes_in=0x01, start -> 8 requests, addresses 0,8,0,8,...; done once; prediction=0x41.
REQ-032 Same, all weights +40 -> out 0 and out 1 both fire in steps 1 and 3; tie; prediction=0x20.
REQ-033 spikes_in=0x00 -> zero w_req pulses; done exactly 2*NUM_STEPS+2 cycles after start; prediction=0x00.
REQ-034 All weights -128, spikes_in=0xFF -> 64 requests; out-0 membrane -1024, -1792, then saturates at -2048; no spikes; prediction=0x00.
REQ-035 Responder latency randomized 1-5 cycles, stray w_valid in IDLE, start pulsed while busy -> w_addr stable during WAIT, stray pulses and extra start without effect; result matches REQ-031.
REQ-036 rst_n low during WAIT, late w_valid delivered after release -> all outputs at reset values; no done; next start completes normally.
